// File: rtl/sync_down_timer.sv
// Loadable down-counter/timer: counts a programmed interval to zero under en and pulses tc.
// Optional macro SYNC_DOWN_TIMER_AUTO_RELOAD_EN turns RUN into periodic mode (reload on terminal count).
module sync_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] eff_count;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;

  // Priority inside every state is load > start > en.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    eff_count = load ? load_val : count_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end
        if (start) begin
          if (eff_count != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
            tc_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
          if (load_val == '0) begin
            state_d = S_DONE;
            tc_d    = 1'b1;
          end
        end else if (en) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            tc_d = 1'b1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
            // Periodic mode: a zero reload value cannot restart, so fall back to DONE.
            if (reload_q != '0) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = S_DONE;
            end
`else
            count_d = '0;
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = S_IDLE;
        end else if (start) begin
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = S_RUN;
          end else begin
            tc_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // busy/done are registered from the next state so they align with the state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// Testbench for sync_down_timer: directed scenarios plus random traffic against a behavioural model.
// Honours SYNC_DOWN_TIMER_AUTO_RELOAD_EN the same way the design does.
module tb_sync_down_timer;
  localparam int W = 4;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clock = 1'b0;
  logic         clear;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  sync_down_timer #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a mode, the remaining interval and the programmed interval.
  int m_mode;
  int m_count;
  int m_reload;
  bit m_tc;

  logic [W+2:0] exp_q[$];

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_count  = 0;
    m_reload = 0;
    m_tc     = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st, input bit e);
    int eff;
    m_tc = 1'b0;
    if (m_mode == M_IDLE) begin
      eff = ld ? lv : m_count;
      if (ld) begin m_count = lv; m_reload = lv; end
      if (st) begin
        if (eff > 0) m_mode = M_RUN;
        else begin m_mode = M_DONE; m_tc = 1'b1; end
      end
    end else if (m_mode == M_RUN) begin
      if (ld) begin
        m_count = lv; m_reload = lv;
        if (lv == 0) begin m_mode = M_DONE; m_tc = 1'b1; end
      end else if (e) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_tc = 1'b1;
          if (AUTO && m_reload > 0) m_count = m_reload;
          else m_mode = M_DONE;
        end
      end
    end else begin
      if (ld) begin m_count = lv; m_reload = lv; m_mode = M_IDLE; end
      else if (st) begin
        if (m_reload > 0) begin m_count = m_reload; m_mode = M_RUN; end
        else m_tc = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit ld, input logic [W-1:0] lv, input bit st, input bit e);
    logic [W+2:0] exp;
    load     = ld;
    load_val = lv;
    start    = st;
    en       = e;
    model_step(ld, int'(lv), st, e);
    exp_q.push_back({m_tc, m_mode == M_RUN, m_mode == M_DONE, W'(m_count)});
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    check("count", 32'(count), 32'(exp[W-1:0]));
    check("tc",    32'(tc),    32'(exp[W+2]));
    check("busy",  32'(busy),  32'(exp[W+1]));
    check("done",  32'(done),  32'(exp[W]));
  endtask

  int busy_cycles;
  int tc_seen_at;
  int tc_pulses;
  bit tc_any;

  initial begin
    clear = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
    model_reset();
    #30;
    check("rst_count", 32'(count), 0);
    check("rst_tc",    32'(tc),    0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    clear = 1'b0;

    // Idle with start low stays idle
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Load 5 and run to terminal count
    step(1'b1, 4'd5, 1'b0, 1'b0);
    check("ld5_count", 32'(count), 5);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    busy_cycles = int'(busy);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      busy_cycles += int'(busy);
    end
    check("run5_busy_cycles", 32'(busy_cycles), 5);
    check("run5_tc",   32'(tc),   1);
    check("run5_done", 32'(done), 1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("run5_tc_once", 32'(tc), 0);

    // Load 6, en toggling: terminal count after 12 clocks
    step(1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    tc_seen_at = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 4'd0, 1'b0, (i % 2) == 0);
      if (tc && tc_seen_at == 0) tc_seen_at = i;
    end
    check("toggle_tc_clock", 32'(tc_seen_at), 12);

    // Reload while running, then zero load aborts into DONE with tc
    step(1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("pre_reload_count", 32'(count), 2);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    check("reload9_count", 32'(count), 9);
    check("reload9_busy",  32'(busy),  1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 1'b0, 1'b1);
    check("zero_load_done", 32'(done), 1);
    check("zero_load_tc",   32'(tc),   1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    // start with reload_reg==0 in DONE pulses tc again
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("zero_restart_tc", 32'(tc), 1);

    // Asynchronous clear mid-run
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("pre_clear_count", 32'(count), 3);
    #2;
    clear = 1'b1;
    #1;
    check("clr_count", 32'(count), 0);
    check("clr_busy",  32'(busy),  0);
    check("clr_tc",    32'(tc),    0);
    model_reset();
    @(negedge clock);
    clear = 1'b0;
    tc_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      tc_any |= tc;
    end
    check("clr_no_tc", 32'(tc_any), 0);
    // Run to DONE, then start reruns from reload_reg
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("rerun_count", 32'(count), 5);
    check("rerun_busy",  32'(busy),  1);
    repeat (6) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Periodic vs single-shot: load 4, start, 20 enabled cycles
    step(1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    tc_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      tc_pulses += int'(tc);
    end
    check("period_tc_pulses", 32'(tc_pulses), AUTO ? 5 : 1);
    check("period_done",      32'(done),      AUTO ? 0 : 1);

    // Maximum interval
    step(1'b1, 4'd15, 1'b1, 1'b1);
    check("max_count", 32'(count), 15);
    repeat (16) step(1'b0, 4'd0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, W'($urandom_range(0, 15)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
